// File: rtl/mult32x32_pkg.sv
// mult32x32_pkg: shared types, constants and helpers for the 32x32 byte-by-halfword sequencer.
// Rev 1.0
`default_nettype none

package mult32x32_pkg;

   localparam int NUM_STEPS = 8;
   localparam int STEP_W    = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      ACCUM = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Byte k[1:0] of A times halfword k[2] of B lands at bit 8*(k[1:0] + 2*k[2]).
   function automatic logic [2:0] step_to_shift(input logic [STEP_W-1:0] step);
      return {1'b0, step[1:0]} + {1'b0, step[2], 1'b0};
   endfunction

endpackage

`default_nettype wire

// File: rtl/mult32x32_step_enc.sv
// mult32x32_step_enc: finds the lowest enabled step after (or at) the current one.
// Rev 1.0
`default_nettype none

module mult32x32_step_enc
   import mult32x32_pkg::*;
(
   input  logic [NUM_STEPS-1:0] mask,
   input  logic [STEP_W-1:0]    cur_step,
   input  logic                 incl_cur,
   output logic [STEP_W-1:0]    next_step,
   output logic                 has_next
);

   // Scan high to low so the last hit is the lowest qualifying index.
   always_comb begin
      next_step = '0;
      has_next  = 1'b0;
      for (int k = NUM_STEPS - 1; k >= 0; k--) begin
         if (mask[k] && ((STEP_W'(k) > cur_step) ||
                         (incl_cur && (STEP_W'(k) == cur_step)))) begin
            next_step = STEP_W'(k);
            has_next  = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/mult32x32_seq_ctrl.sv
// mult32x32_seq_ctrl: sequences clear and partial-product steps of the 32x32 arith unit.
// Rev 1.0
`default_nettype none

module mult32x32_seq_ctrl
   import mult32x32_pkg::*;
#(
   parameter bit SKIP_ZERO = 1'b0
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] a_in,
   input  logic [31:0] b_in,
   output logic [31:0] a_op,
   output logic [31:0] b_op,
   output logic [1:0]  a_sel,
   output logic        b_sel,
   output logic [2:0]  shift_sel,
   output logic        upd_prod,
   output logic        clr_prod,
   output logic        busy,
   output logic        done
);

   state_t               state_q, state_d;
   logic [STEP_W-1:0]    step_q, step_d;
   logic [31:0]          a_op_q, a_op_d;
   logic [31:0]          b_op_q, b_op_d;
   logic [NUM_STEPS-1:0] step_mask;
   logic [STEP_W-1:0]    enc_cur;
   logic                 enc_incl;
   logic [STEP_W-1:0]    enc_next;
   logic                 enc_has_next;

   if (SKIP_ZERO) begin : g_skip_zero
      for (genvar k = 0; k < NUM_STEPS; k++) begin : g_mask
         assign step_mask[k] = (a_op_q[8*(k%4) +: 8] != 8'd0) &&
                               (b_op_q[16*(k/4) +: 16] != 16'd0);
      end
   end else begin : g_all_steps
      assign step_mask = '1;
   end

   // From CLEAR the search includes step 0; from ACCUM it starts past the current step.
   assign enc_cur  = (state_q == ACCUM) ? step_q : '0;
   assign enc_incl = (state_q != ACCUM);

   mult32x32_step_enc u_step_enc (
      .mask      (step_mask),
      .cur_step  (enc_cur),
      .incl_cur  (enc_incl),
      .next_step (enc_next),
      .has_next  (enc_has_next)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         step_q  <= '0;
         a_op_q  <= '0;
         b_op_q  <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         a_op_q  <= a_op_d;
         b_op_q  <= b_op_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      a_op_d    = a_op_q;
      b_op_d    = b_op_q;
      a_sel     = 2'd0;
      b_sel     = 1'b0;
      shift_sel = 3'd0;
      upd_prod  = 1'b0;
      clr_prod  = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               a_op_d  = a_in;
               b_op_d  = b_in;
               state_d = CLEAR;
            end
         end
         CLEAR, ACCUM: begin
            upd_prod = 1'b1;
            busy     = 1'b1;
            if (state_q == CLEAR) begin
               clr_prod = 1'b1;
            end else begin
               a_sel     = step_q[1:0];
               b_sel     = step_q[2];
               shift_sel = step_to_shift(step_q);
            end
            if (enc_has_next) begin
               step_d  = enc_next;
               state_d = ACCUM;
            end else begin
               state_d = DONE;
            end
         end
         DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            step_d  = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign a_op = a_op_q;
   assign b_op = b_op_q;

endmodule

`default_nettype wire

// File: tb/tb_mult32x32_seq_ctrl.sv
// tb_mult32x32_seq_ctrl: directed bench pairing the sequencer with a behavioural arith unit.
// Rev 1.0
`default_nettype none

module tb_mult32x32_seq_ctrl;
   import mult32x32_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start0, start1;
   logic [31:0] a_in, b_in;

   // Instance 0: SKIP_ZERO=0, instance 1: SKIP_ZERO=1
   logic [31:0] a_op0, b_op0, a_op1, b_op1;
   logic [1:0]  a_sel0, a_sel1;
   logic        b_sel0, b_sel1;
   logic [2:0]  sh0, sh1;
   logic        upd0, clr0, busy0, done0, upd1, clr1, busy1, done1;
   logic [63:0] prod0, prod1;

   int          sel;
   logic [9:0]  m_stat;
   logic [31:0] m_aop, m_bop;
   logic [63:0] m_prod;
   logic        m_upd, m_clr, m_busy, m_done;
   logic [2:0]  m_k, m_sh;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   mult32x32_seq_ctrl #(.SKIP_ZERO(1'b0)) dut0 (
      .clk(clk), .reset(reset), .start(start0), .a_in(a_in), .b_in(b_in),
      .a_op(a_op0), .b_op(b_op0), .a_sel(a_sel0), .b_sel(b_sel0), .shift_sel(sh0),
      .upd_prod(upd0), .clr_prod(clr0), .busy(busy0), .done(done0)
   );

   mult32x32_seq_ctrl #(.SKIP_ZERO(1'b1)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .a_in(a_in), .b_in(b_in),
      .a_op(a_op1), .b_op(b_op1), .a_sel(a_sel1), .b_sel(b_sel1), .shift_sel(sh1),
      .upd_prod(upd1), .clr_prod(clr1), .busy(busy1), .done(done1)
   );

   function automatic logic [63:0] pp(input logic [31:0] a, input logic [31:0] b,
                                      input logic [1:0] as, input logic bs,
                                      input logic [2:0] sh);
      logic [7:0]  ab;
      logic [15:0] bh;
      ab = a[8*as +: 8];
      bh = b[16*bs +: 16];
      return (64'(ab) * 64'(bh)) << (8 * sh);
   endfunction

   // Arithmetic unit: product register sharing the controller reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prod0 <= '0;
         prod1 <= '0;
      end else begin
         if (upd0) prod0 <= clr0 ? 64'd0 : prod0 + pp(a_op0, b_op0, a_sel0, b_sel0, sh0);
         if (upd1) prod1 <= clr1 ? 64'd0 : prod1 + pp(a_op1, b_op1, a_sel1, b_sel1, sh1);
      end
   end

   always_comb begin
      if (sel == 1) begin
         m_upd = upd1; m_clr = clr1; m_busy = busy1; m_done = done1;
         m_k = {b_sel1, a_sel1}; m_sh = sh1;
         m_aop = a_op1; m_bop = b_op1; m_prod = prod1;
      end else begin
         m_upd = upd0; m_clr = clr0; m_busy = busy0; m_done = done0;
         m_k = {b_sel0, a_sel0}; m_sh = sh0;
         m_aop = a_op0; m_bop = b_op0; m_prod = prod0;
      end
      m_stat = {m_upd, m_clr, m_busy, m_done, m_k, m_sh};
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One accepted start; checks CLEAR/DONE status, step order, timing and product.
   task automatic run_op(input int s, input string tag,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp_p, input int exp_d, input int exp_n,
                         input logic [23:0] exp_k, input logic [23:0] exp_sh);
      int          cyc;
      int          dcyc;
      int          nacc;
      logic [23:0] ks;
      logic [23:0] shs;
      sel  = s;
      a_in = a;
      b_in = b;
      if (s == 1) start1 = 1'b1; else start0 = 1'b1;
      cyc = 0; dcyc = -1; nacc = 0; ks = '0; shs = '0;
      while (dcyc < 0 && cyc < 40) begin
         tick();
         cyc++;
         start0 = 1'b0;
         start1 = 1'b0;
         a_in   = ~a;
         b_in   = ~b;
         if (cyc == 1) chk({tag, " clear stat"}, 64'(m_stat), 64'(10'b1110_000_000));
         if (m_upd && !m_clr) begin
            nacc++;
            ks  = {ks[20:0], m_k};
            shs = {shs[20:0], m_sh};
         end
         if (m_done) dcyc = cyc;
      end
      chk({tag, " done cycle"}, 64'(dcyc), 64'(exp_d));
      chk({tag, " done stat"}, 64'(m_stat), 64'(10'b0011_000_000));
      chk({tag, " product"}, m_prod, exp_p);
      chk({tag, " steps"}, 64'(nacc), 64'(exp_n));
      chk({tag, " step order"}, 64'(ks), 64'(exp_k));
      chk({tag, " shift order"}, 64'(shs), 64'(exp_sh));
      chk({tag, " a_op"}, 64'(m_aop), 64'(a));
      chk({tag, " b_op"}, 64'(m_bop), 64'(b));
      tick();
      chk({tag, " idle stat"}, 64'(m_stat), 64'd0);
      chk({tag, " product hold"}, m_prod, exp_p);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int busy_drop;
      int idle_cnt;
      int dq[$];

      reset = 1'b1; start0 = 1'b0; start1 = 1'b0; a_in = '0; b_in = '0; sel = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset stat0", 64'(m_stat), 64'd0);
      chk("reset ops0", {m_aop, m_bop}, 64'd0);
      sel = 1;
      #1;
      chk("reset stat1", 64'(m_stat), 64'd0);
      chk("reset prod1", m_prod, 64'd0);
      reset = 1'b0;
      tick();

      run_op(0, "full ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001,
             10, 8, 24'o01234567, 24'o01232345);

      run_op(1, "skip 5x7", 32'd5, 32'd7, 64'd35, 3, 1, 24'o0, 24'o0);
      run_op(1, "skip k6", 32'h00FF_0000, 32'h0001_0000, 64'h0000_00FF_0000_0000,
             3, 1, 24'o6, 24'o4);
      run_op(1, "skip 4 steps", 32'hFF00_0001, 32'h0002_0003, 64'h0001_FE02_FD02_0003,
             6, 4, 24'o0347, 24'o0325);
      run_op(1, "skip zero a", 32'h0000_0000, 32'h0000_1234, 64'd0, 2, 0, 24'o0, 24'o0);

      // Start pulses while busy and during DONE must be ignored
      sel = 0; a_in = 32'h0100_0002; b_in = 32'h0003_0004; start0 = 1'b1;
      busy_drop = 0; dq.delete();
      for (int cyc = 1; cyc <= 12; cyc++) begin
         tick();
         start0 = (cyc == 3 || cyc == 10);
         a_in   = 32'hFFFF_FFFF;
         b_in   = 32'hFFFF_FFFF;
         if (cyc <= 10 && !m_busy) busy_drop++;
         if (m_done) dq.push_back(cyc);
         if (cyc == 10) chk("ignore product", m_prod, 64'h0000_0300_0406_0008);
         if (cyc == 11) chk("ignore idle after done", 64'(m_busy), 64'd0);
      end
      start0 = 1'b0;
      chk("ignore busy held", 64'(busy_drop), 64'd0);
      chk("ignore done count", 64'(dq.size()), 64'd1);
      chk("ignore a_op", 64'(m_aop), 64'h0100_0002);
      chk("ignore b_op", 64'(m_bop), 64'h0003_0004);

      // Asynchronous reset in the middle of a run
      sel = 0; a_in = 32'hFFFF_FFFF; b_in = 32'hFFFF_FFFF; start0 = 1'b1;
      for (int cyc = 1; cyc <= 5; cyc++) begin
         tick();
         start0 = 1'b0;
      end
      chk("pre-reset busy", 64'(m_busy), 64'd1);
      reset = 1'b1;
      #1;
      chk("mid reset stat", 64'(m_stat), 64'd0);
      chk("mid reset ops", {m_aop, m_bop}, 64'd0);
      chk("mid reset prod", m_prod, 64'd0);
      chk("mid reset state", 64'(dut0.state_q), 64'(IDLE));
      tick();
      reset = 1'b0;
      tick();
      chk("post reset stat", 64'(m_stat), 64'd0);
      run_op(0, "after reset", 32'h0001_0000, 32'h0003_0000, 64'h0000_0003_0000_0000,
             10, 8, 24'o01234567, 24'o01232345);

      // Start held high for 30 cycles: back-to-back runs
      sel = 0; a_in = 32'd2; b_in = 32'd2; start0 = 1'b1;
      idle_cnt = 0; dq.delete();
      for (int cyc = 1; cyc <= 40; cyc++) begin
         tick();
         if (cyc == 30) start0 = 1'b0;
         if (m_done) dq.push_back(cyc);
         if (cyc <= 32 && !m_busy) idle_cnt++;
         if (cyc == 11 || cyc == 22) chk("held idle gap", 64'(m_busy), 64'd0);
      end
      chk("held done count", 64'(dq.size()), 64'd3);
      if (dq.size() == 3) begin
         chk("held done 1", 64'(dq[0]), 64'd10);
         chk("held spacing 1", 64'(dq[1] - dq[0]), 64'd11);
         chk("held spacing 2", 64'(dq[2] - dq[1]), 64'd11);
      end
      chk("held idle count", 64'(idle_cnt), 64'd2);
      chk("held product", m_prod, 64'd4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

`default_nettype wire
